// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter for the Bridge peripheral bus.
// The CPU pushes bytes into a small TX FIFO through the DATA register. A four-state
// FSM pops them and shifts each one out LSB first on tx: one start bit, eight data
// bits and one stop bit. Every bit lasts DIVISOR clock cycles.
// IRQ (when IE is set) reports that the FIFO is drained and the line is idle.
//
// Bus handshake: WE is a single-cycle write strobe. A write is accepted at the clock
// edge that ends the cycle in which WE is high. There is no ready or back-pressure
// signal; a DATA write into a full FIFO is dropped and recorded in the sticky
// overflow flag. Reads are purely combinational from Addr[3:2] and have no side
// effects.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:2] Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_DIV    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Register state
    // ---------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_en;
    logic          r_ie;
    logic [15:0]   r_div;
    logic          r_irq;

    state_t        r_state;
    logic [7:0]    r_shift;
    logic [15:0]   r_cnt;
    logic [15:0]   r_bitlen;
    logic [2:0]    r_bit_idx;
    logic          r_tx;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic [1:0]    w_off;
    logic          w_wr_data;
    logic          w_wr_status;
    logic          w_wr_ctrl;
    logic          w_wr_div;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [7:0]    w_head;
    logic [15:0]   w_div_eff;
    logic          w_cnt_done;
    logic          w_busy;
    logic [7:0]    w_count8;

    state_t        w_state_next;
    logic [7:0]    w_shift_next;
    logic [15:0]   w_cnt_next;
    logic [15:0]   w_bitlen_next;
    logic [2:0]    w_idx_next;
    logic          w_tx_next;

    // Upper address bits and upper data bits are not decoded.
    logic          w_unused;

    assign w_unused    = ^{Addr[31:4], Din[31:16]};

    assign w_off       = Addr[3:2];
    assign w_wr_data   = WE && (w_off == OFF_DATA);
    assign w_wr_status = WE && (w_off == OFF_STATUS);
    assign w_wr_ctrl   = WE && (w_off == OFF_CTRL);
    assign w_wr_div    = WE && (w_off == OFF_DIV);

    // Full is sampled before the edge, so a push into a full FIFO is dropped
    // even when the FSM pops in the same cycle.
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = w_wr_data && !w_full;
    assign w_drop      = w_wr_data && w_full;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_cnt_done  = (r_cnt == 16'd0);
    assign w_busy      = (r_state != S_IDLE);
    assign w_count8    = 8'(r_count);

    assign tx          = r_tx;
    assign IRQ         = r_irq;

    // ---------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are meaningless while count=0)
    // ---------------------------------------------------------------------
    // Write the pushed byte into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= Din[7:0];
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    // CTRL, DIVISOR and the sticky overflow flag; any STATUS write clears overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= Din[0];
                r_ie <= Din[1];
            end
            if (w_wr_div) begin
                r_div <= Din[15:0];
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Registered interrupt: FIFO drained and transmitter idle, gated by IE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ie && w_empty && (r_state == S_IDLE);
        end
    end

    // ---------------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------------
    // FSM state and datapath registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'd0;
            r_cnt     <= 16'd0;
            r_bitlen  <= 16'd1;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_cnt     <= w_cnt_next;
            r_bitlen  <= w_bitlen_next;
            r_bit_idx <= w_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state logic. The bit length is latched when a frame starts, so a
    // DIVISOR write mid-frame only affects the next frame. The counter is loaded
    // with bitlen-1 and each bit ends when the counter reaches zero.
    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_shift_next  = r_shift;
        w_cnt_next    = r_cnt;
        w_bitlen_next = r_bitlen;
        w_idx_next    = r_bit_idx;
        w_tx_next     = r_tx;

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (r_en && !w_empty) begin
                    w_state_next  = S_START;
                    w_pop         = 1'b1;
                    w_shift_next  = w_head;
                    w_bitlen_next = w_div_eff;
                    w_cnt_next    = w_div_eff - 16'd1;
                    w_tx_next     = 1'b0;
                end
            end

            S_START: begin
                if (w_cnt_done) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                    w_idx_next   = 3'd0;
                    w_cnt_next   = r_bitlen - 16'd1;
                end else begin
                    w_cnt_next   = r_cnt - 16'd1;
                end
            end

            S_DATA: begin
                if (w_cnt_done) begin
                    w_cnt_next = r_bitlen - 16'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                        w_idx_next   = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            S_STOP: begin
                if (w_cnt_done) begin
                    if (r_en && !w_empty) begin
                        // Back-to-back: the next start bit follows with no idle gap.
                        w_state_next  = S_START;
                        w_pop         = 1'b1;
                        w_shift_next  = w_head;
                        w_bitlen_next = w_div_eff;
                        w_cnt_next    = w_div_eff - 16'd1;
                        w_tx_next     = 1'b0;
                    end else begin
                        w_state_next  = S_IDLE;
                        w_tx_next     = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    // Combinational read data selected by the register offset.
    always_comb begin
        Dout = 32'd0;
        case (w_off)
            OFF_DATA:   Dout = 32'd0;
            OFF_STATUS: Dout = {16'd0, w_count8, 4'd0, r_ovf, w_empty, w_full, w_busy};
            OFF_CTRL:   Dout = {30'd0, r_ie, r_en};
            OFF_DIV:    Dout = {16'd0, r_div};
            default:    Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed testbench for uart_tx_dev: reset values, register access, single and
// back-to-back frames, DIVISOR=0, FIFO overflow, IRQ behaviour, EN cleared
// mid-frame and reset mid-frame.
module tb_uart_tx_dev;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [31:2] Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] ovf_bytes [9] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                                  8'hAB, 8'hCD, 8'hEF, 8'h5A};

    uart_tx_dev #(
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .WE   (WE),
        .Addr (Addr),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ),
        .tx   (tx)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checks ----------------
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
        Addr = {28'd0, off};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
        Addr = {28'd0, off};
        #1;
        d = Dout;
    endtask

    task automatic wait_start(input int max_cycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (tx === 1'b0) ok = 1'b1;
            else step();
        end
    endtask

    // Called at the first cycle of a start bit; checks the whole frame cycle by
    // cycle against {stop, data, start} and checks busy throughout.
    task automatic check_line(input string tag, input logic [7:0] b, input int bl);
        logic [9:0]  frame;
        logic [31:0] st;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * bl; k++) begin
            chk1({tag, "_tx"}, tx, frame[k / bl]);
            bus_read(2'd1, st);
            chk1({tag, "_busy"}, st[0], 1'b1);
            step();
        end
    endtask

    // Receiver: finds a start bit and samples each bit in its middle.
    task automatic rx_byte(input int bl, output logic [7:0] b);
        logic ok;
        b = 8'd0;
        wait_start(200, ok);
        chk1("rx_start_seen", ok, 1'b1);
        repeat (bl + bl / 2) step();
        b[0] = tx;
        for (int i = 1; i < 8; i++) begin
            repeat (bl) step();
            b[i] = tx;
        end
        repeat (bl) step();
        chk1("rx_stop_bit", tx, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [7:0]  got;
        logic        ok;
        int          n;
        int          lows;

        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = 32'd0;

        // Reset: hold two cycles.
        step();
        step();
        reset = 1'b0;
        chk1("reset_tx", tx, 1'b1);
        chk1("reset_irq", IRQ, 1'b0);
        bus_read(2'd1, rd);
        chk32("reset_status", rd, 32'h0000_0004);
        bus_read(2'd3, rd);
        chk32("reset_divisor", rd, 32'h0000_0010);
        bus_read(2'd2, rd);
        chk32("reset_ctrl", rd, 32'h0);

        // Register access: unused bits ignored, DATA reads zero.
        bus_write(2'd2, 32'hFFFF_FFFC);
        bus_read(2'd2, rd);
        chk32("ctrl_unused_bits", rd, 32'h0);
        bus_write(2'd3, 32'hABCD_0004);
        bus_read(2'd3, rd);
        chk32("divisor_rw", rd, 32'h0000_0004);
        bus_read(2'd0, rd);
        chk32("data_reads_zero", rd, 32'h0);

        // Single byte 0xA5 at DIVISOR=4: tx falls at the edge after the write edge.
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'hA5);
        chk1("single_latency_pre", tx, 1'b1);
        step();
        check_line("single", 8'hA5, 4);
        bus_read(2'd1, rd);
        chk32("single_done_status", rd, 32'h0000_0004);
        chk1("single_done_tx", tx, 1'b1);

        // Back-to-back 0x00, 0xFF at DIVISOR=2: 40 contiguous cycles.
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h2);
        bus_write(2'd0, 32'h00);
        bus_write(2'd0, 32'hFF);
        bus_read(2'd1, rd);
        chk32("b2b_loaded", rd, 32'h0000_0200);
        bus_write(2'd2, 32'h1);
        chk1("b2b_latency_pre", tx, 1'b1);
        step();
        check_line("b2b_first", 8'h00, 2);
        check_line("b2b_second", 8'hFF, 2);
        bus_read(2'd1, rd);
        chk32("b2b_done_status", rd, 32'h0000_0004);

        // DIVISOR=0 behaves as one cycle per bit.
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd);
        chk32("div0_reads_zero", rd, 32'h0);
        bus_write(2'd0, 32'h81);
        chk1("div0_latency_pre", tx, 1'b1);
        step();
        check_line("div0", 8'h81, 1);
        chk1("div0_done_tx", tx, 1'b1);

        // Overflow: nine writes with EN=0 into an eight-entry FIFO.
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h2);
        for (int i = 0; i < 9; i++) begin
            bus_write(2'd0, {24'd0, ovf_bytes[i]});
            if (i < 8) exp_q.push_back(ovf_bytes[i]);
        end
        bus_read(2'd1, rd);
        chk32("ovf_status", rd, 32'h0000_080A);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, rd);
        chk32("ovf_cleared", rd, 32'h0000_0802);
        bus_write(2'd2, 32'h1);
        for (int i = 0; i < 8; i++) begin
            rx_byte(2, got);
            chk32("ovf_order", {24'd0, got}, {24'd0, exp_q.pop_front()});
        end
        repeat (3) step();
        bus_read(2'd1, rd);
        chk32("ovf_drained", rd, 32'h0000_0004);

        // IRQ: enable IE with the FIFO empty and idle.
        bus_write(2'd2, 32'h3);
        step();
        chk1("irq_idle_set", IRQ, 1'b1);
        bus_write(2'd0, 32'h55);
        wait_start(10, ok);
        chk1("irq_start_seen", ok, 1'b1);
        for (int k = 0; k < 20; k++) begin
            chk1("irq_low_busy", IRQ, 1'b0);
            step();
        end
        bus_read(2'd1, rd);
        chk32("irq_frame_done", rd, 32'h0000_0004);
        chk1("irq_lags_idle", IRQ, 1'b0);
        step();
        chk1("irq_rises", IRQ, 1'b1);
        bus_write(2'd0, 32'h00);
        step();
        chk1("irq_drop_on_push", IRQ, 1'b0);
        rx_byte(2, got);
        chk32("irq_second_byte", {24'd0, got}, 32'h00);
        repeat (3) step();
        chk1("irq_after_second", IRQ, 1'b1);
        bus_write(2'd2, 32'h1);
        step();
        chk1("irq_ie_cleared", IRQ, 1'b0);

        // EN cleared mid-frame: current frame finishes, next byte waits.
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'hC3);
        bus_write(2'd0, 32'h5A);
        bus_write(2'd2, 32'h1);
        wait_start(10, ok);
        chk1("en_clear_start_seen", ok, 1'b1);
        repeat (5) step();
        bus_write(2'd2, 32'h0);
        n = 6;
        bus_read(2'd1, rd);
        while (rd[0] && n < 100) begin
            step();
            n++;
            bus_read(2'd1, rd);
        end
        chk32("en_clear_frame_len", n, 20);
        chk32("en_clear_status", rd, 32'h0000_0100);
        repeat (10) step();
        bus_read(2'd1, rd);
        chk32("en_clear_stays_idle", rd, 32'h0000_0100);
        chk1("en_clear_tx_idle", tx, 1'b1);
        bus_write(2'd2, 32'h1);
        rx_byte(2, got);
        chk32("en_clear_resume_byte", {24'd0, got}, 32'h5A);
        repeat (3) step();

        // Reset mid-frame during bit 3 of 0x3C, with another byte queued.
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'h3C);
        bus_write(2'd0, 32'h99);
        bus_write(2'd2, 32'h1);
        wait_start(10, ok);
        chk1("rst_start_seen", ok, 1'b1);
        repeat (4) step();
        chk1("rst_bit1_low", tx, 1'b0);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk1("rst_tx_high", tx, 1'b1);
        chk1("rst_irq_low", IRQ, 1'b0);
        bus_read(2'd1, rd);
        chk32("rst_status", rd, 32'h0000_0004);
        bus_read(2'd2, rd);
        chk32("rst_ctrl", rd, 32'h0);
        bus_read(2'd3, rd);
        chk32("rst_divisor", rd, 32'h0000_0010);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            if (tx !== 1'b1) lows++;
            step();
        end
        chk32("rst_no_frame", lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
